// File: rtl/firebird7_in_gate2_ijtag_seq_pkg.sv
// Shared encodings and constants for the IJTAG SIB sequencing controller.
// Length and settle-counter widths live here so the shifter and the FSM agree.
package firebird7_in_gate2_ijtag_seq_pkg;

  localparam int LEN_W          = 6;
  localparam int WAIT_W         = 8;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPEN_CAP,
    ST_OPEN_SHIFT,
    ST_OPEN_UPD,
    ST_OPEN_WAIT,
    ST_CAP,
    ST_SHIFT,
    ST_UPD,
    ST_WAIT,
    ST_RESP
  } state_t;

  // A host scan needs at least one bit and must fit the data register.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int data_w);
    return (len != '0) && (len <= LEN_W'(data_w));
  endfunction

endpackage

// File: rtl/firebird7_in_gate2_ijtag_seq_shifter.sv
// Scan datapath: si shift register, so capture register and the 0..N bit counter.
// One bit per cycle while enabled; no backpressure, the FSM owns sequencing.
module firebird7_in_gate2_ijtag_seq_shifter
  import firebird7_in_gate2_ijtag_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_open,
  input  logic              load_scan,
  input  logic              sr_shift,
  input  logic              sample,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  input  logic              close,
  input  logic              so,
  output logic              si,
  output logic [DATA_W-1:0] cap,
  output logic              sib_err,
  output logic              cnt_done
);

  logic [DATA_W:0]    sr_q;
  logic [DATA_W:0]    scan_img;
  logic [LEN_W-1:0]   cnt_q;

  // Host bits below len, then the SIB control bit right after them.
  always_comb begin
    scan_img = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (LEN_W'(i) < len) scan_img[i] = data[i];
    end
    for (int i = 0; i <= DATA_W; i++) begin
      if (LEN_W'(i) == len) scan_img[i] = ~close;
    end
  end

  assign si       = sr_q[0];
  assign cnt_done = (cnt_q == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      cap     <= '0;
      sib_err <= 1'b0;
    end else begin
      if (clr) begin
        sr_q    <= '0;
        cnt_q   <= '0;
        cap     <= '0;
        sib_err <= 1'b0;
      end else if (load_open) begin
        sr_q <= {{DATA_W{1'b0}}, 1'b1};
      end else if (load_scan) begin
        sr_q  <= scan_img;
        cnt_q <= '0;
      end else if (sr_shift) begin
        sr_q <= {1'b0, sr_q[DATA_W:1]};
      end

      // Sample 0 is the SIB cell; samples 1..N land in cap[0..N-1].
      if (sample) begin
        if (cnt_q == '0) sib_err <= so;
        for (int i = 0; i < DATA_W; i++) begin
          if (cnt_q == LEN_W'(i + 1)) cap[i] <= so;
        end
        if (!cnt_done) cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/firebird7_in_gate2_ijtag_seq_ctrl.sv
// IJTAG SIB scan sequencer: opens the SIB if needed, scans N host bits, reports capture.
// Latency N+10 edges (SIB closed) or N+5 (open) at SETTLE_CYC=2; response held until rsp_ready.
module firebird7_in_gate2_ijtag_seq_ctrl
  import firebird7_in_gate2_ijtag_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_close,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              sib_open,
  output logic              ijtag_sel,
  output logic              ijtag_ce,
  output logic              ijtag_se,
  output logic              ijtag_ue,
  output logic              ijtag_si,
  input  logic              ijtag_so
);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   data_q;
  logic                close_q;
  logic                len_err_q;
  logic                rst_done_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                accept;
  logic                len_ok;
  logic                wait_done;
  logic                cnt_done;
  logic                sib_err;

  // rst_done_q keeps req_ready low until the first edge after reset release.
  assign req_ready = (state_q == ST_IDLE) && rst_done_q;
  assign accept    = req_valid && req_ready;
  assign len_ok    = len_legal(req_len, DATA_W);
  assign wait_done = (wait_q == WAIT_W'(SETTLE_CYC - 1));
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = len_err_q | sib_err;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      close_q    <= 1'b0;
      len_err_q  <= 1'b0;
      sib_open   <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      if (accept) begin
        len_q     <= req_len;
        data_q    <= req_data;
        close_q   <= req_close;
        len_err_q <= ~len_ok;
      end
      if (state_q == ST_OPEN_UPD)  sib_open <= 1'b1;
      else if (state_q == ST_UPD)  sib_open <= ~close_q;
      if (state_q == ST_OPEN_WAIT || state_q == ST_WAIT) wait_q <= wait_q + WAIT_W'(1);
      else                                               wait_q <= '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    ijtag_sel = 1'b1;
    ijtag_ce  = 1'b0;
    ijtag_se  = 1'b0;
    ijtag_ue  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ijtag_sel = 1'b0;
        if (accept) begin
          if (!len_ok)       state_d = ST_RESP;
          else if (sib_open) state_d = ST_CAP;
          else               state_d = ST_OPEN_CAP;
        end
      end
      ST_OPEN_CAP: begin
        ijtag_ce = 1'b1;
        state_d  = ST_OPEN_SHIFT;
      end
      ST_OPEN_SHIFT: begin
        ijtag_se = 1'b1;
        state_d  = ST_OPEN_UPD;
      end
      ST_OPEN_UPD: begin
        ijtag_ue = 1'b1;
        state_d  = ST_OPEN_WAIT;
      end
      ST_OPEN_WAIT: if (wait_done) state_d = ST_CAP;
      ST_CAP: begin
        ijtag_ce = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        ijtag_se = 1'b1;
        if (cnt_done) state_d = ST_UPD;
      end
      ST_UPD: begin
        ijtag_ue = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: if (wait_done) state_d = ST_RESP;
      ST_RESP: begin
        ijtag_sel = 1'b0;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        ijtag_sel = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  firebird7_in_gate2_ijtag_seq_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk       (ijtag_tck),
    .rst_n     (ijtag_reset),
    .clr       (accept),
    .load_open (state_q == ST_OPEN_CAP),
    .load_scan (state_q == ST_CAP),
    .sr_shift  (state_q == ST_OPEN_SHIFT || state_q == ST_SHIFT),
    .sample    (state_q == ST_SHIFT),
    .len       (len_q),
    .data      (data_q),
    .close     (close_q),
    .so        (ijtag_so),
    .si        (ijtag_si),
    .cap       (rsp_data),
    .sib_err   (sib_err),
    .cnt_done  (cnt_done)
  );

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_seq_ctrl.sv
// Bench for the IJTAG SIB sequencer with a SIB + 8-bit host TDR scan-image model.
// Requests push expected responses to a scoreboard; a monitor pops and checks them.
`timescale 1ns/1ps
module tb_firebird7_in_gate2_ijtag_seq_ctrl;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset;
  logic        req_valid, req_ready, req_close;
  logic [5:0]  req_len;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_ready, rsp_err, sib_open;
  logic [31:0] rsp_data;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate2_ijtag_seq_ctrl #(.DATA_W(32), .SETTLE_CYC(2)) dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_len     (req_len),
    .req_data    (req_data),
    .req_close   (req_close),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .sib_open    (sib_open),
    .ijtag_sel   (ijtag_sel),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_si    (ijtag_si),
    .ijtag_so    (ijtag_so)
  );

  // Network model: capture loads {tdr, SIB cell=0}, shifted out LSB first;
  // update writes the last shifted bit to the SIB and the first 8 to the TDR.
  logic [7:0] tdr;
  logic       sib;
  logic [8:0] img, sin;
  logic [3:0] mcnt;
  logic       img_open;

  always @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      tdr <= 8'h3C; sib <= 1'b0; img <= '0; sin <= '0; mcnt <= '0; img_open <= 1'b0;
    end else if (ijtag_sel && ijtag_ce) begin
      img      <= sib ? {tdr, 1'b0} : 9'b0;
      img_open <= sib;
      mcnt     <= '0;
    end else if (ijtag_sel && ijtag_se) begin
      img <= {1'b0, img[8:1]};
      if (mcnt < 4'd9) begin
        sin[mcnt] <= ijtag_si;
        mcnt      <= mcnt + 4'd1;
      end
    end else if (ijtag_sel && ijtag_ue && mcnt != 4'd0) begin
      sib <= sin[mcnt - 4'd1];
      if (img_open && mcnt == 4'd9) tdr <= sin[7:0];
    end
  end
  assign ijtag_so = img[0];

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        sib;
    int          lat;
    int          ue;
    logic        sel;
    int          hold;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0, acc_cyc = 0, n_acc = 0, ue_seen = 0, n_rsp = 0;
  logic sel_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge ijtag_tck) cyc++;

  always @(negedge ijtag_tck) begin
    if (req_valid && req_ready) begin
      acc_cyc  = cyc + 1;
      n_acc++;
      ue_seen  = 0;
      sel_seen = 1'b0;
    end else begin
      if (ijtag_ue)  ue_seen++;
      if (ijtag_sel) sel_seen = 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge ijtag_tck); #1;
      if (ijtag_reset === 1'b1 && rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_data",    64'(rsp_data),      64'(e.data));
          check("rsp_err",     64'(rsp_err),       64'(e.err));
          check("sib_open",    64'(sib_open),      64'(e.sib));
          check("latency",     64'(cyc - acc_cyc), 64'(e.lat));
          check("ue_pulses",   64'(ue_seen),       64'(e.ue));
          check("sel_active",  64'(sel_seen),      64'(e.sel));
          check("ready_excl",  64'(req_ready),     64'd0);
          for (int h = 0; h < e.hold; h++) begin
            @(negedge ijtag_tck); #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_data",  64'(rsp_data),  64'(e.data));
            check("hold_err",   64'(rsp_err),   64'(e.err));
            check("hold_ready", 64'(req_ready), 64'd0);
          end
        end
        rsp_ready = 1'b1;
        @(negedge ijtag_tck); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 64'(rsp_valid), 64'd0);
        n_rsp++;
      end
    end
  end

  task automatic issue(input logic [5:0] len, input logic [31:0] data, input logic close,
                       input logic [31:0] xd, input logic xe, input logic xs, input int xl,
                       input int xu, input logic xsel, input int hold);
    exp_t e;
    int   n;
    e.data = xd; e.err = xe; e.sib = xs; e.lat = xl; e.ue = xu; e.sel = xsel; e.hold = hold;
    sb.push_back(e);
    @(posedge ijtag_tck); #1;
    req_valid = 1'b1; req_len = len; req_data = data; req_close = close;
    n = 0;
    do begin
      @(negedge ijtag_tck);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge ijtag_tck); #1;
    // Scramble request fields after accept; the transaction must not notice.
    req_valid = 1'b0; req_len = 6'd5; req_data = ~data; req_close = ~close;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (n_rsp < target && n < 300) begin
      @(posedge ijtag_tck);
      n++;
    end
    if (n_rsp < target) check("rsp_timeout", 64'(n_rsp), 64'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},  64'(req_ready), 64'd0);
    check({tag, "_vld"},  64'(rsp_valid), 64'd0);
    check({tag, "_data"}, 64'(rsp_data),  64'd0);
    check({tag, "_err"},  64'(rsp_err),   64'd0);
    check({tag, "_sib"},  64'(sib_open),  64'd0);
    check({tag, "_pins"}, 64'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}), 64'd0);
  endtask

  initial begin : main
    int n;
    ijtag_reset = 1'b0;
    req_valid = 1'b0; req_len = '0; req_data = '0; req_close = 1'b0;
    repeat (3) @(posedge ijtag_tck);
    #1;
    check_idle_outputs("reset");
    ijtag_reset = 1'b1;
    repeat (2) @(posedge ijtag_tck);
    #1;
    check("ready_after_release", 64'(req_ready), 64'd1);

    // Closed SIB: OPEN phase first, TDR preload comes back.
    issue(6'd8, 32'h0000_00A5, 1'b0, 32'h0000_003C, 1'b0, 1'b1, 18, 2, 1'b1, 0);
    wait_rsp(1);
    // Already open: direct scan, previous data comes back, SIB closes.
    issue(6'd8, 32'h0000_005A, 1'b1, 32'h0000_00A5, 1'b0, 1'b0, 13, 1, 1'b1, 0);
    wait_rsp(2);
    // Illegal lengths: straight to RESP, no network activity.
    issue(6'd0,  32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
    wait_rsp(3);
    issue(6'd33, 32'h0000_1234, 1'b1, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
    wait_rsp(4);

    // Reset in the middle of the host SHIFT.
    issue(6'd8, 32'h0000_0077, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    n = 0;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge ijtag_tck);
      if (ijtag_se) n++;
    end
    check("se_reached", 64'(n), 64'd5);
    #2;
    ijtag_reset = 1'b0;
    #1;
    check_idle_outputs("midscan_reset");
    sb.delete();
    repeat (2) @(posedge ijtag_tck);
    #1;
    ijtag_reset = 1'b1;
    repeat (2) @(posedge ijtag_tck);

    issue(6'd8, 32'h0000_0011, 1'b0, 32'h0000_003C, 1'b0, 1'b1, 18, 2, 1'b1, 0);
    wait_rsp(5);

    // Response held for 5 cycles; a req_valid pulse meanwhile must be ignored.
    issue(6'd8, 32'h0000_00C3, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 13, 1, 1'b1, 5);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge ijtag_tck);
      n++;
    end
    @(posedge ijtag_tck); #1;
    req_valid = 1'b1;
    @(posedge ijtag_tck); #1;
    req_valid = 1'b0;
    wait_rsp(6);
    repeat (4) @(posedge ijtag_tck);

    check("accept_count", 64'(n_acc), 64'd7);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
